beam_power_acc: RTL and testbench
=================================

// Module: beam_power_acc
// PURPOSE
//   Parametrised, pipelined successor to the 4-element combinational steering-vector correlator.
//   Per accepted snapshot it computes y = sum_k conj(s_k)*x_k over N_CH channels.
//   It accumulates |y|^2 over n_snap consecutive snapshots and emits one beam-power word per block.
//   Sits between the sample/steering-vector feeder and the DOA spectrum peak search.
//   Valid/ready handshake on both sides.
// PARAMETERS
//   WORD_LENGTH  12                                  signed width of each I/Q input sample
//   N_CH         4                                   channel (array element) count, >=2
//   CNT_W        8                                   width of n_snap; max block = 2^CNT_W-1 snapshots
//   DOT_W        2*WORD_LENGTH+1+$clog2(N_CH)        signed width of Re/Im of y (27 at defaults)
//   MAG_W        2*DOT_W                             unsigned width of |y|^2
//   ACC_W        MAG_W+CNT_W                         unsigned width of power output
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous active-low reset
//   clear      in   1                 synchronous flush of pipeline, counter, accumulator and output
//   in_valid   in   1                 snapshot + steering vector present
//   in_ready   out  1                 block can accept the snapshot this cycle
//   x_i, x_q   in   N_CH*WORD_LENGTH  sample I/Q; channel k in bits [k*WL +: WL], signed
//   s_i, s_q   in   N_CH*WORD_LENGTH  steering vector I/Q, same packing, signed
//   n_snap     in   CNT_W             snapshots per block; sampled on first snapshot of block; 0 => 1
//   out_valid  out  1                 power holds a completed block result
//   out_ready  in   1                 consumer takes power when out_valid && out_ready
//   power      out  ACC_W             sum over block of |y|^2, unsigned
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valids, snapshot counter, accumulator, power and out_valid = 0.
//     State = IDLE. in_ready = 0 while rst_n = 0.
//   Stall: stall = out_valid && !out_ready.
//     in_ready = !stall.
//     While stalled, every pipeline register, counter and power hold their value.
//   Input FSM (advances on accept = in_valid && in_ready):
//     IDLE : on accept, latch nmax = (n_snap==0 ? 1 : n_snap).
//            Tag first=1, last=(nmax==1). cnt = 1. Go to ACCUM unless last.
//     ACCUM: on accept, tag first=0, last=(cnt+1==nmax). cnt++.
//            Return to IDLE (cnt=0) when last.
//     n_snap changes mid-block are ignored.
//   Pipeline (each stage advances when !stall):
//     S1: register 4*N_CH products.
//     S2: re = sum(Is*Ix + Qs*Qx), im = sum(Is*Qx - Qs*Ix), sign-extended to DOT_W.
//     S3: mag = re*re + im*im, in MAG_W bits, exact.
//     S4: acc = first ? mag : acc + mag.
//         If last: power <= (first ? mag : acc + mag) and out_valid <= 1.
//   Latency: 4 cycles from accepting the last snapshot of a block to out_valid=1 (no stall).
//     Throughput is 1 snapshot/cycle; back-to-back blocks need no idle cycle.
//   out_valid clears on the handshake cycle unless a new result loads in that same cycle.
//     A new result may load the same cycle the old one is taken.
//   No overflow is possible: ACC_W covers (2^CNT_W-1) full-scale snapshots.
//   clear (sync) has priority over all other activity that cycle.
//     Zeroes valids, cnt, acc, out_valid and power. FSM -> IDLE. In-flight snapshots are discarded.
//     in_ready stays 1 during clear; any snapshot offered that cycle is dropped.
//   Async reset mid-block: same as power-on; the partial block is lost with no output.
// TESTING
//   1. N_CH=4, all x=s=(100+0j), n_snap=1, one accept at cycle t
//      -> out_valid=1 at t+4, power=1_600_000_000, valid for one cycle with out_ready=1.
//   2. Same vectors, n_snap=3, 3 back-to-back accepts
//      -> exactly one result, power=4_800_000_000, 4 cycles after 3rd accept.
//      n_snap=0 behaves as n_snap=1.
//   3. Extremes: x=(-2048-2048j), s=(-2048-2048j) all channels, n_snap=255
//      -> re=2^25, im=0, power=255*2^50, no wrap.
//      Also check x=(1+2j), s=(3+4j) -> re=11, im=2, mag=125 per channel-set.
//   4. Hold out_ready=0 while out_valid=1 for 10 cycles with in_valid=1
//      -> in_ready=0, power stable, no snapshot lost.
//      After release, results continue in order against a reference model.
//   5. Assert clear after 2 of 3 snapshots -> no output.
//      Next block of 1 snapshot gives only its own power; the partial sum is not included.
//   6. Drop rst_n mid-block and mid-stall -> out_valid=0, power=0 immediately (async).
//      After release, a fresh block is accepted and correct.

Source files
------------

// File: rtl/beam_power_acc.sv
// Pipelined beam-power accumulator: y = sum_k conj(s_k)*x_k per snapshot,
// |y|^2 summed over n_snap snapshots, one power word per block.
module beam_power_acc #(
    parameter  int unsigned WORD_LENGTH = 12,
    parameter  int unsigned N_CH        = 4,
    parameter  int unsigned CNT_W       = 8,
    localparam int unsigned DOT_W       = 2 * WORD_LENGTH + 1 + $clog2(N_CH),
    localparam int unsigned MAG_W       = 2 * DOT_W,
    localparam int unsigned ACC_W       = MAG_W + CNT_W,
    localparam int unsigned BUS_W       = N_CH * WORD_LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] x_i,
    input  logic [BUS_W-1:0] x_q,
    input  logic [BUS_W-1:0] s_i,
    input  logic [BUS_W-1:0] s_q,
    input  logic [CNT_W-1:0] n_snap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] power
);
    localparam int unsigned PROD_W = 2 * WORD_LENGTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, nmax_q, nmax_d;
    logic              stall, accept, tag_first, tag_last;

    logic              s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic              s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
    logic              s3_valid_q, s3_valid_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
    logic signed [PROD_W-1:0] p_ii_q[N_CH], p_ii_d[N_CH], p_qq_q[N_CH], p_qq_d[N_CH];
    logic signed [PROD_W-1:0] p_iq_q[N_CH], p_iq_d[N_CH], p_qi_q[N_CH], p_qi_d[N_CH];
    logic signed [WORD_LENGTH-1:0] xi_l[N_CH], xq_l[N_CH], si_l[N_CH], sq_l[N_CH];
    logic signed [DOT_W-1:0]  re_q, re_d, im_q, im_d, re_c, im_c;
    logic signed [MAG_W-1:0]  re_x, im_x;
    logic [MAG_W-1:0]  mag_q, mag_d, mag_c;
    logic [ACC_W-1:0]  acc_q, acc_d, power_q, power_d, sum_c;
    logic              out_valid_q, out_valid_d;

    // A held result freezes the whole pipeline; clear always gets through
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = rst_n && (clear || !stall);
    assign accept    = in_valid && in_ready && !clear;
    assign out_valid = out_valid_q;
    assign power     = power_q;

    // Block framing: tag each accepted snapshot as first/last of its block
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nmax_d    = nmax_q;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    nmax_d    = (n_snap == '0) ? CNT_W'(1) : n_snap;
                    tag_first = 1'b1;
                    tag_last  = (nmax_d == CNT_W'(1));
                    cnt_d     = tag_last ? '0 : CNT_W'(1);
                    state_d   = tag_last ? IDLE : ACCUM;
                end
                ACCUM: begin
                    tag_last = (cnt_q + CNT_W'(1) == nmax_q);
                    cnt_d    = tag_last ? '0 : cnt_q + CNT_W'(1);
                    state_d  = tag_last ? IDLE : ACCUM;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            xi_l[k] = x_i[k * WORD_LENGTH +: WORD_LENGTH];
            xq_l[k] = x_q[k * WORD_LENGTH +: WORD_LENGTH];
            si_l[k] = s_i[k * WORD_LENGTH +: WORD_LENGTH];
            sq_l[k] = s_q[k * WORD_LENGTH +: WORD_LENGTH];
        end
    end

    // Dot product of conj(s) with x, and its exact squared magnitude
    always_comb begin
        re_c = '0;
        im_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            re_c = re_c + DOT_W'(p_ii_q[k]) + DOT_W'(p_qq_q[k]);
            im_c = im_c + DOT_W'(p_iq_q[k]) - DOT_W'(p_qi_q[k]);
        end
        re_x  = MAG_W'(re_q);
        im_x  = MAG_W'(im_q);
        mag_c = MAG_W'(re_x * re_x + im_x * im_x);
        sum_c = s3_first_q ? ACC_W'(mag_q) : acc_q + ACC_W'(mag_q);
    end

    always_comb begin
        s1_valid_d = s1_valid_q; s1_first_d = s1_first_q; s1_last_d = s1_last_q;
        s2_valid_d = s2_valid_q; s2_first_d = s2_first_q; s2_last_d = s2_last_q;
        s3_valid_d = s3_valid_q; s3_first_d = s3_first_q; s3_last_d = s3_last_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            p_ii_d[k] = p_ii_q[k];
            p_qq_d[k] = p_qq_q[k];
            p_iq_d[k] = p_iq_q[k];
            p_qi_d[k] = p_qi_q[k];
        end
        re_d        = re_q;
        im_d        = im_q;
        mag_d       = mag_q;
        acc_d       = acc_q;
        power_d     = power_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
            s3_valid_d  = 1'b0;
            acc_d       = '0;
            power_d     = '0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            s1_valid_d = accept;
            s1_first_d = tag_first;
            s1_last_d  = tag_last;
            for (int k = 0; k < int'(N_CH); k++) begin
                p_ii_d[k] = PROD_W'(si_l[k]) * PROD_W'(xi_l[k]);
                p_qq_d[k] = PROD_W'(sq_l[k]) * PROD_W'(xq_l[k]);
                p_iq_d[k] = PROD_W'(si_l[k]) * PROD_W'(xq_l[k]);
                p_qi_d[k] = PROD_W'(sq_l[k]) * PROD_W'(xi_l[k]);
            end
            s2_valid_d  = s1_valid_q;
            s2_first_d  = s1_first_q;
            s2_last_d   = s1_last_q;
            re_d        = re_c;
            im_d        = im_c;
            s3_valid_d  = s2_valid_q;
            s3_first_d  = s2_first_q;
            s3_last_d   = s2_last_q;
            mag_d       = mag_c;
            out_valid_d = s3_valid_q && s3_last_q;
            if (s3_valid_q) begin
                acc_d = sum_c;
                if (s3_last_q) power_d = sum_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nmax_q      <= '0;
            s1_valid_q  <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
            s2_valid_q  <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
            s3_valid_q  <= 1'b0; s3_first_q <= 1'b0; s3_last_q <= 1'b0;
            for (int k = 0; k < int'(N_CH); k++) begin
                p_ii_q[k] <= '0;
                p_qq_q[k] <= '0;
                p_iq_q[k] <= '0;
                p_qi_q[k] <= '0;
            end
            re_q        <= '0;
            im_q        <= '0;
            mag_q       <= '0;
            acc_q       <= '0;
            power_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nmax_q      <= nmax_d;
            s1_valid_q  <= s1_valid_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
            s2_valid_q  <= s2_valid_d; s2_first_q <= s2_first_d; s2_last_q <= s2_last_d;
            s3_valid_q  <= s3_valid_d; s3_first_q <= s3_first_d; s3_last_q <= s3_last_d;
            for (int k = 0; k < int'(N_CH); k++) begin
                p_ii_q[k] <= p_ii_d[k];
                p_qq_q[k] <= p_qq_d[k];
                p_iq_q[k] <= p_iq_d[k];
                p_qi_q[k] <= p_qi_d[k];
            end
            re_q        <= re_d;
            im_q        <= im_d;
            mag_q       <= mag_d;
            acc_q       <= acc_d;
            power_q     <= power_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_beam_power_acc.sv
// Directed bench for beam_power_acc: hand-computed block powers plus a
// queue-based block model checked on every output handshake.
module tb_beam_power_acc;
    localparam int unsigned WL = 12;
    localparam int unsigned NC = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 2 * (2 * WL + 1 + $clog2(NC)) + CW;
    localparam int unsigned BW = NC * WL;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready, out_valid, out_ready;
    logic [BW-1:0] x_i, x_q, s_i, s_q;
    logic [CW-1:0] n_snap;
    logic [AW-1:0] power;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beam_power_acc #(.WORD_LENGTH(WL), .N_CH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_i(x_i), .x_q(x_q), .s_i(s_i), .s_q(s_q), .n_snap(n_snap),
        .out_valid(out_valid), .out_ready(out_ready), .power(power)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // |sum_k conj(s_k) x_k|^2 with plain integer arithmetic
    function automatic logic [63:0] snap_mag(input logic [BW-1:0] xi, xq, si, sq);
        longint re = 0;
        longint im = 0;
        logic signed [WL-1:0] a, b, c, d;
        for (int k = 0; k < int'(NC); k++) begin
            a = xi[k*WL +: WL];
            b = xq[k*WL +: WL];
            c = si[k*WL +: WL];
            d = sq[k*WL +: WL];
            re += longint'(c) * longint'(a) + longint'(d) * longint'(b);
            im += longint'(c) * longint'(b) - longint'(d) * longint'(a);
        end
        return 64'(re * re + im * im);
    endfunction

    // Block model: expected powers queued in completion order
    logic [63:0] exp_q[$];
    int          m_cnt  = 0;
    int          m_nmax = 0;
    logic [63:0] m_sum  = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] pow_prev   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt      = 0;
            stall_prev = 1'b0;
        end else if (clear) begin
            exp_q.delete();
            m_cnt      = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_power", 64'(power), pow_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got power %0d expected no result", power);
                end else begin
                    check("power_vs_model", 64'(power), exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            pow_prev   = 64'(power);
            if (in_valid && in_ready) begin
                if (m_cnt == 0) begin
                    m_nmax = (n_snap == 0) ? 1 : int'(n_snap);
                    m_sum  = 0;
                end
                m_sum += snap_mag(x_i, x_q, s_i, s_q);
                m_cnt++;
                if (m_cnt == m_nmax) begin
                    exp_q.push_back(m_sum);
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic set_all(input int xi, input int xq, input int si, input int sq);
        for (int k = 0; k < int'(NC); k++) begin
            x_i[k*WL +: WL] = WL'(xi);
            x_q[k*WL +: WL] = WL'(xq);
            s_i[k*WL +: WL] = WL'(si);
            s_q[k*WL +: WL] = WL'(sq);
        end
    endtask

    // Entered and left at posedge+1; t_acc is the cycle the snapshot was taken
    task automatic send(input int n, output int t_acc);
        bit done = 1'b0;
        n_snap   = CW'(n);
        in_valid = 1'b1;
        t_acc    = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !clear) begin
                done  = 1'b1;
                t_acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic wait_out(output int tv);
        tv = -1;
        for (int i = 0; i < 100 && tv < 0; i++) begin
            @(negedge clk);
            if (out_valid) tv = cyc;
        end
        if (tv < 0) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got out_valid=0 for 100 cycles expected a result");
        end
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, tv;
        logic [63:0] big;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_snap = '0;
        set_all(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_power", 64'(power), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        resync();
        rst_n = 1'b1;

        // Single-snapshot block, all channels 100+0j
        set_all(100, 0, 100, 0);
        check("model_pin_100", snap_mag(x_i, x_q, s_i, s_q), 64'd1600000000);
        send(1, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("t1_latency", 64'(tv), 64'(t + 4));
        check("t1_power", 64'(power), 64'd1600000000);
        @(negedge clk);
        check("t1_one_cycle", 64'(out_valid), 64'd0);
        resync();

        // Three-snapshot block, then n_snap=0 acting as 1
        send(3, t); send(3, t); send(3, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("t2_latency", 64'(tv), 64'(t + 4));
        check("t2_power", 64'(power), 64'd4800000000);
        resync();
        send(0, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("t2_nsnap0_latency", 64'(tv), 64'(t + 4));
        check("t2_nsnap0_power", 64'(power), 64'd1600000000);
        resync();

        // Full-scale corner over a 255-snapshot block; n_snap changes mid-block
        set_all(-2048, -2048, -2048, -2048);
        check("model_pin_fullscale", snap_mag(x_i, x_q, s_i, s_q), 64'd1 << 50);
        send(255, t);
        for (int i = 0; i < 254; i++) send(1, t);
        in_valid = 1'b0;
        wait_out(tv);
        big = 64'd255 << 50;
        check("t3_latency", 64'(tv), 64'(t + 4));
        check("t3_power", 64'(power), big);
        resync();

        // One active channel: (3-4j)(1+2j) = 11+2j, |.|^2 = 125
        set_all(0, 0, 0, 0);
        x_i[0 +: WL] = WL'(1); x_q[0 +: WL] = WL'(2);
        s_i[0 +: WL] = WL'(3); s_q[0 +: WL] = WL'(4);
        check("model_pin_125", snap_mag(x_i, x_q, s_i, s_q), 64'd125);
        send(1, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("t3_small_power", 64'(power), 64'd125);
        resync();

        // Back-pressure: four blocks in flight, fifth held off for 10 cycles
        out_ready = 1'b0;
        set_all(100, 0, 100, 0);
        send(1, t);
        for (int i = 1; i < 4; i++) begin
            set_all(i + 1, -3 * i, 7, 2 * i);
            send(1, t);
        end
        set_all(-9, 11, 13, -5);
        n_snap = CW'(1);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_power", 64'(power), 64'd1600000000);
        end
        resync();
        out_ready = 1'b1;
        send(1, t);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("stall_drained", 64'(exp_q.size()), 64'd0);
        resync();

        // Clear after 2 of 3 snapshots discards the partial block
        set_all(100, 0, 100, 0);
        send(3, t); send(3, t);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 64'(in_ready), 64'd1);
        resync();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("clear_no_output", 64'(out_valid), 64'd0);
        end
        resync();
        set_all(10, 0, 10, 0);
        send(1, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("clear_next_latency", 64'(tv), 64'(t + 4));
        check("clear_next_power", 64'(power), 64'd160000);
        resync();

        // Async reset with a stalled result and a partial block in flight
        out_ready = 1'b0;
        set_all(100, 0, 100, 0);
        send(1, t);
        send(3, t); send(3, t);
        in_valid = 1'b0;
        wait_out(tv);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_power", 64'(power), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        resync();
        rst_n = 1'b1;
        out_ready = 1'b1;
        // (2-7j)(5-3j) = -11-41j per channel; 4 channels -> 28832, plus 1.6e9
        set_all(5, -3, 2, 7);
        send(2, t);
        set_all(100, 0, 100, 0);
        send(2, t);
        in_valid = 1'b0;
        wait_out(tv);
        check("rst_fresh_latency", 64'(tv), 64'(t + 4));
        check("rst_fresh_power", 64'(power), 64'd1600028832);
        resync();

        repeat (8) @(negedge clk);
        check("model_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time 200000 expected completion");
        $fatal(1);
    end

endmodule
